// File: rtl/signed_sum_accumulator_pkg.sv
// Shared types and clamp helpers for the signed frame accumulator.
// Imported by signed_sat_add and signed_sum_accumulator.
package signed_acc_pkg;

    typedef enum logic {
        StAccum,
        StHold
    } state_e;

    function automatic int max_pos(input int w);
        return (1 << (w - 1)) - 1;
    endfunction

    function automatic int max_neg(input int w);
        return -(1 << (w - 1));
    endfunction

endpackage

// File: rtl/signed_sum_accumulator_if.sv
// Sample-in / total-out valid-ready bundle for signed_sum_accumulator.
// master drives samples and accepts totals; slave is the accumulator side.
interface signed_sum_accumulator_if #(
    parameter int IN_W  = 5,
    parameter int ACC_W = 6
) ();
    logic                    in_valid;
    logic signed [IN_W-1:0]  in_data;
    logic                    in_ready;
    logic                    out_valid;
    logic signed [ACC_W-1:0] out_data;
    logic                    out_sat;
    logic                    out_ready;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  out_sat,
        output out_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output out_valid,
        output out_data,
        output out_sat,
        input  out_ready
    );
endinterface

// File: rtl/signed_sum_accumulator_sat_add.sv
// W-bit signed adder with optional clamping; SAT_EN selects clamp vs. wrap.
// This is the only place the SAT_EN macro is consulted.
module signed_sat_add
    import signed_acc_pkg::*;
#(
    parameter int W = 6
) (
    input  logic signed [W-1:0] a,
    input  logic signed [W-1:0] b,
    output logic signed [W-1:0] res,
    output logic                sat
);
`ifdef SAT_EN
    logic signed [W:0] sum;

    assign sum = {a[W-1], a} + {b[W-1], b};

    // Top two bits disagree only when the true sum left the W-bit range.
    always_comb begin
        res = sum[W-1:0];
        sat = 1'b0;
        if (sum[W] != sum[W-1]) begin
            sat = 1'b1;
            res = sum[W] ? W'(max_neg(W)) : W'(max_pos(W));
        end
    end
`else
    assign res = a + b;
    assign sat = 1'b0;
`endif
endmodule

// File: rtl/signed_sum_accumulator.sv
// Accumulates COUNT signed samples per frame and offers the total downstream.
// Define SAT_EN to clamp each addition instead of wrapping.
module signed_sum_accumulator
    import signed_acc_pkg::*;
#(
    parameter int IN_W  = 5,
    parameter int ACC_W = 6,
    parameter int COUNT = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    signed_sum_accumulator_if.slave bus
);
    localparam int CntW = $clog2(COUNT);
    localparam logic [CntW-1:0] LastCnt = CntW'(COUNT - 1);

    state_e                  state_q, state_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic signed [ACC_W-1:0] out_data_q, out_data_d;
    logic [CntW-1:0]         cnt_q, cnt_d;
    logic                    sat_q, sat_d;
    logic                    out_sat_q, out_sat_d;
    logic                    live_q;
    logic signed [ACC_W-1:0] sample_ext;
    logic signed [ACC_W-1:0] sum;
    logic                    sum_sat;
    logic                    accept;

    assign sample_ext = {{(ACC_W - IN_W){bus.in_data[IN_W-1]}}, bus.in_data};

    signed_sat_add #(
        .W(ACC_W)
    ) u_add (
        .a  (acc_q),
        .b  (sample_ext),
        .res(sum),
        .sat(sum_sat)
    );

    // live_q keeps in_ready low for the cycle following a reset edge.
    assign bus.in_ready  = live_q && (state_q == StAccum);
    assign bus.out_valid = (state_q == StHold);
    assign bus.out_data  = out_data_q;
    assign bus.out_sat   = out_sat_q;
    assign accept        = bus.in_valid && bus.in_ready;

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        out_data_d = out_data_q;
        cnt_d      = cnt_q;
        sat_d      = sat_q;
        out_sat_d  = out_sat_q;
        unique case (state_q)
            StAccum: begin
                if (accept) begin
                    acc_d = sum;
                    if (cnt_q == LastCnt) begin
                        out_data_d = sum;
                        out_sat_d  = sat_q | sum_sat;
                        sat_d      = 1'b0;
                        cnt_d      = '0;
                        state_d    = StHold;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                        sat_d = sat_q | sum_sat;
                    end
                end
            end
            StHold: begin
                if (bus.out_ready) begin
                    acc_d     = '0;
                    out_sat_d = 1'b0;
                    state_d   = StAccum;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= StAccum;
            acc_q      <= '0;
            out_data_q <= '0;
            cnt_q      <= '0;
            sat_q      <= 1'b0;
            out_sat_q  <= 1'b0;
            live_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            out_data_q <= out_data_d;
            cnt_q      <= cnt_d;
            sat_q      <= sat_d;
            out_sat_q  <= out_sat_d;
            live_q     <= 1'b1;
        end
    end
endmodule

// File: tb/tb_signed_sum_accumulator.sv
// Directed self-checking bench for signed_sum_accumulator (COUNT=4, 5-in/6-acc).
// Expected totals follow SAT_EN, matching however the RTL is built.
module tb_signed_sum_accumulator;
    logic clk;
    logic reset;
    int   n_cmp;
    int   n_bad;

    signed_sum_accumulator_if #(.IN_W(5), .ACC_W(6)) bus ();

    signed_sum_accumulator #(
        .IN_W (5),
        .ACC_W(6),
        .COUNT(4)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Offers one sample and returns #1 after the edge that accepted it.
    task automatic send(input logic signed [4:0] v);
        int t;
        bus.in_valid = 1'b1;
        bus.in_data  = v;
        t = 0;
        while (bus.in_ready !== 1'b1 && t < 20) begin
            @(posedge clk);
            #1;
            t++;
        end
        n_cmp++;
        if (t >= 20) begin
            n_bad++;
            $display("FAIL send_ready_timeout: in_ready=%b after %0d cycles, required 1",
                     bus.in_ready, t);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic frame4(input logic signed [4:0] a, input logic signed [4:0] b,
                          input logic signed [4:0] c, input logic signed [4:0] d);
        send(a);
        send(b);
        send(c);
        send(d);
    endtask

    task automatic drain();
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        n_cmp++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL drain: out_valid=%b in_ready=%b, required 0/1",
                     bus.out_valid, bus.in_ready);
        end
    endtask

    task automatic test_reset();
        reset        = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = 5'sd3;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            n_cmp++;
            if (bus.out_valid !== 1'b0 || bus.out_data !== 6'sd0 || bus.in_ready !== 1'b0
                || bus.out_sat !== 1'b0) begin
                n_bad++;
                $display("FAIL reset_hold[%0d]: v=%b d=%0d r=%b s=%b, required 0/0/0/0",
                         i, bus.out_valid, bus.out_data, bus.in_ready, bus.out_sat);
            end
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        n_cmp++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_release: in_ready=%b out_valid=%b, required 1/0",
                     bus.in_ready, bus.out_valid);
        end
    endtask

    task automatic test_normal();
        bus.out_ready = 1'b1;
        send(5'sd3);
        send(-5'sd5);
        send(5'sd7);
        n_cmp++;
        if (bus.out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL normal_early_valid: out_valid=%b, required 0", bus.out_valid);
        end
        send(5'sd1);
        n_cmp++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 6'sd6 || bus.out_sat !== 1'b0) begin
            n_bad++;
            $display("FAIL normal_total: v=%b d=%0d s=%b, required 1/6/0",
                     bus.out_valid, bus.out_data, bus.out_sat);
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        n_cmp++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL normal_handshake: v=%b r=%b, required 0/1",
                     bus.out_valid, bus.in_ready);
        end
    endtask

    task automatic test_overflow();
        logic signed [5:0] exp_d;
        logic              exp_s;
`ifdef SAT_EN
        exp_d = 6'sd31;
        exp_s = 1'b1;
`else
        exp_d = -6'sd4;
        exp_s = 1'b0;
`endif
        frame4(5'sd15, 5'sd15, 5'sd15, 5'sd15);
        n_cmp++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== exp_d || bus.out_sat !== exp_s) begin
            n_bad++;
            $display("FAIL overflow: v=%b d=%0d s=%b, required 1/%0d/%b",
                     bus.out_valid, bus.out_data, bus.out_sat, exp_d, exp_s);
        end
        drain();
    endtask

    task automatic test_underflow();
        logic signed [5:0] exp_d;
        logic              exp_s;
`ifdef SAT_EN
        exp_d = -6'sd32;
        exp_s = 1'b1;
`else
        exp_d = 6'sd0;
        exp_s = 1'b0;
`endif
        frame4(-5'sd16, -5'sd16, -5'sd16, -5'sd16);
        n_cmp++;
        if (bus.out_data !== exp_d || bus.out_sat !== exp_s) begin
            n_bad++;
            $display("FAIL underflow: d=%0d s=%b, required %0d/%b",
                     bus.out_data, bus.out_sat, exp_d, exp_s);
        end
        drain();
`ifdef SAT_EN
        exp_d = 6'sd15;
        exp_s = 1'b1;
`else
        exp_d = 6'sd29;
        exp_s = 1'b0;
`endif
        frame4(5'sd15, 5'sd15, 5'sd15, -5'sd16);
        n_cmp++;
        if (bus.out_data !== exp_d || bus.out_sat !== exp_s) begin
            n_bad++;
            $display("FAIL clamp_then_sub: d=%0d s=%b, required %0d/%b",
                     bus.out_data, bus.out_sat, exp_d, exp_s);
        end
        drain();
    endtask

    task automatic test_back_to_back();
        frame4(5'sd1, 5'sd1, 5'sd1, 5'sd1);
        bus.in_valid = 1'b1;
        bus.in_data  = 5'sd9;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            n_cmp++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== 6'sd4 || bus.in_ready !== 1'b0) begin
                n_bad++;
                $display("FAIL backpressure[%0d]: v=%b d=%0d r=%b, required 1/4/0",
                         i, bus.out_valid, bus.out_data, bus.in_ready);
            end
        end
        // Sample 9 is still offered across the handshake edge and must be ignored.
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        frame4(5'sd1, 5'sd2, 5'sd3, -5'sd1);
        n_cmp++;
        if (bus.out_data !== 6'sd5 || bus.out_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL after_backpressure: v=%b d=%0d, required 1/5",
                     bus.out_valid, bus.out_data);
        end
        drain();
    endtask

    task automatic test_reset_mid();
        send(5'sd7);
        send(5'sd7);
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        n_cmp++;
        if (bus.out_valid !== 1'b0 || bus.out_data !== 6'sd0) begin
            n_bad++;
            $display("FAIL reset_mid_clear: v=%b d=%0d, required 0/0",
                     bus.out_valid, bus.out_data);
        end
        frame4(5'sd1, 5'sd2, 5'sd3, 5'sd4);
        n_cmp++;
        if (bus.out_data !== 6'sd10 || bus.out_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_mid_total: v=%b d=%0d, required 1/10",
                     bus.out_valid, bus.out_data);
        end
        drain();
    endtask

    initial begin
        n_cmp         = 0;
        n_bad         = 0;
        reset         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        #1;
        test_reset();
        test_normal();
        test_overflow();
        test_underflow();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/signed_sum_accumulator.md
# signed_sum_accumulator

Downstream consumer of the registered 5-bit signed adder result. Accepts a stream of signed sums over a valid/ready handshake and accumulates a fixed-size frame of COUNT samples. Presents the frame total on a valid/ready output port, with optional saturation.

## Interface
- IN_W, 5: width of the signed input sample (matches the adder's C output).
- ACC_W, 6: width of the signed accumulator and output; range -2^(ACC_W-1) .. 2^(ACC_W-1)-1.
- COUNT, 4: samples per frame; must be ≥ 2.
- clk  in  1  single clock, all logic on rising edge.
- reset  in  1  synchronous, active-low reset; sampled on rising clk only.
- in_valid  in  1  upstream sample valid.
- in_data  in  IN_W  signed sample.
- in_ready  out  1  block can accept a sample this cycle.
- out_valid  out  1  frame total valid.
- out_data  out  ACC_W  signed frame total.
- out_sat  out  1  frame total was clamped (only meaningful with SAT_EN).
- out_ready  in  1  downstream accepts total.

## Operation
- FSM states:
  - ACCUM: in_ready=1, out_valid=0.
  - HOLD: in_ready=0, out_valid=1.
- Reset (reset=0 at a rising edge), regardless of state:
  - state=ACCUM, acc=0, cnt=0, out_valid=0, out_data=0, out_sat=0, in_ready=0 during the reset cycle.
- ACCUM, on in_valid && in_ready:
  - acc ← acc + sext(in_data); cnt ← cnt+1.
  - If this is sample COUNT-1 (cnt == COUNT-1): load out_data with the new sum, load out_sat, cnt ← 0, state ← HOLD.
- ACCUM with in_valid=0: no change (gaps allowed).
- HOLD:
  - out_data and out_sat stable.
  - On out_ready=1: acc ← 0, out_sat ← 0, state ← ACCUM.
  - out_ready=0: stay in HOLD, hold all outputs.
- Arithmetic:
  - Sign-extend in_data to ACC_W+1 bits and add to sign-extended acc.
  - Result is clamped (SAT_EN) or truncated to ACC_W bits (wrap).
- Saturation is applied per addition, not only at frame end. Once clamped, subsequent samples add to the clamped value.
- out_sat is sticky within a frame: set if any addition in the frame clamped.

## Timing
- in_ready is combinational from state only; no combinational path from in_valid or out_ready.
- Output latency: out_valid rises on the cycle after the clk edge that accepted sample COUNT-1.
- Throughput:
  - No bypass. The sample offered during the out handshake cycle is not accepted (in_ready=0).
  - First sample of the next frame is accepted earliest 1 cycle after the out handshake.
  - Max rate: COUNT+1 cycles per frame.
- Reset mid-frame discards the partial sum. Reset in HOLD drops the pending total without a handshake.
- cnt is $clog2(COUNT) bits and wraps to 0 only via the frame-complete path.

## Configuration
- SAT_EN defined:
  - Each addition clamps to MAXPOS = 2^(ACC_W-1)-1 or MAXNEG = -2^(ACC_W-1).
  - out_sat reports clamping.
- SAT_EN undefined:
  - Two's-complement wrap to ACC_W bits.
  - out_sat tied to 0; no saturation logic synthesized.

## Structure
- Package signed_acc_pkg:
  - state enum (ACCUM, HOLD).
  - Functions returning MAXPOS/MAXNEG for a given width.
- Sub-module signed_sat_add (parameter W):
  - Inputs: two W-bit signed operands.
  - Outputs: W-bit result and sat flag.
  - Its internals are the only `ifdef SAT_EN` site.

## Test plan
- Reset: hold reset=0 for 2 cycles with in_valid=1 → out_valid=0, out_data=0, in_ready=0. Then release reset → in_ready=1 on the next cycle.
- Normal frame: samples 3, -5, 7, 1 on consecutive cycles, out_ready=1 → out_data=6, out_sat=0, out_valid high 1 cycle after the 4th accept.
- Overflow, four samples of 15:
  - SAT_EN: out_data=31, out_sat=1.
  - No SAT_EN: out_data=-4, out_sat=0.
- Underflow, four samples of -16:
  - SAT_EN: out_data=-32, out_sat=1.
  - No SAT_EN: out_data=0.
  - Also check 15,15,15,-16 with SAT_EN → clamps to 31 then 31-16=15, out_sat=1.
- Backpressure: after frame 1,1,1,1 hold out_ready=0 for 3 cycles with in_valid=1 → out_data=4 stable, in_ready=0, no samples consumed. Release out_ready → next frame starts from acc=0.
- Reset mid-frame: accept 7,7, assert reset=0 for 1 cycle, then send 1,2,3,4 → out_data=10.
